message_schedule: RTL and testbench
===================================

MESSAGE_SCHEDULE -- requirements
Module: message_schedule

Interface
REQ-001 The block SHALL have no parameters; word width is fixed at 32 bits, block width at 512 bits, and rounds at 64.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data_in  input  512  padded message block from message_build; word 0 = bits 511:480 (big-endian word order).
REQ-005 data_in_last  input  1  marks the final block of a message.
REQ-006 data_in_valid  input  1  the upstream block is valid.
REQ-007 data_in_ready  output  1  the block can accept a new block.
REQ-008 data_out  output  32  schedule word W[t].
REQ-009 data_out_index  output  6  round index t of data_out (0..63).
REQ-010 data_out_last  output  1  high only with W[63] of a block captured with data_in_last=1.
REQ-011 data_out_valid  output  1  the output word is valid.
REQ-012 data_out_ready  input  1  the downstream consumer accepts the word.

Function
REQ-013 Both ports SHALL use a valid/ready handshake: a transfer occurs on a rising edge where valid and ready are both 1.
REQ-014 The FSM SHALL have states IDLE and EMIT, and SHALL reset to IDLE.
REQ-015 In IDLE, data_in_ready SHALL be 1 and data_out_valid SHALL be 0; in EMIT, data_in_ready SHALL be 0 and data_out_valid SHALL be 1; both outputs SHALL be registered.
REQ-016 On an input transfer, the block SHALL load words 0..15 into window w[0..15], latch data_in_last, clear t to 0, and enter EMIT; data_out_valid SHALL rise on the next cycle (1-cycle latency).
REQ-017 In EMIT, data_out SHALL equal w[0] and data_out_index SHALL equal t.
REQ-018 On each output transfer, the window SHALL shift (w[i] <= w[i+1]) with w[15] <= sigma1(w[14]) + w[9] + sigma0(w[1]) + w[0], using mod-2^32 addition; t SHALL increment.
REQ-019 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-020 When data_out_valid=1 and data_out_ready=0, data_out, data_out_index and data_out_last SHALL hold stable.
REQ-021 On the output transfer with t=63, the FSM SHALL return to IDLE; data_in_ready SHALL be 1 on the next cycle, and t SHALL not wrap to 0 within EMIT.
REQ-022 Throughput SHALL be 1 block per 65 cycles with data_out_ready held at 1; each block SHALL produce exactly 64 output transfers.
REQ-023 data_out_last SHALL be (t==63) AND latched data_in_last; the latched last flag SHALL NOT change during EMIT.
REQ-024 The data_in_* inputs SHALL be ignored in EMIT, even if data_in_valid=1.

Reset
REQ-025 While rst=1, at each rising edge: state=IDLE, t=0, window=0, latched last=0, data_in_ready=0, data_out_valid=0, data_out=0, data_out_index=0, data_out_last=0.
REQ-026 data_in_ready SHALL be 1 in the first cycle after rst is deasserted.
REQ-027 When rst is asserted in EMIT, the block SHALL abandon the current block, emit no further words, and discard the captured data.

Verification
REQ-028 "abc" block (0x61626380, 14 zero words, 0x00000018), last=1, ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; data_out_last=1 only at index 63.
REQ-029 All-zero block, last=0 -> 64 transfers, all data_out=0, data_out_last never 1, data_in_ready=1 one cycle after the index-63 transfer.
REQ-030 "abc" block with data_out_ready toggling 1-0-0-1 randomly -> data_out/index stable while stalled; the word sequence is identical to REQ-028.
REQ-031 Two back-to-back blocks (last=0 then last=1), data_in_valid held high -> the second block is accepted exactly 1 cycle after the first block's t=63 transfer; data_out_last is set only at the second block's W63.
REQ-032 rst asserted at t=20 -> data_out_valid=0 the next cycle; a following "abc" block restarts at index 0 with W0=0x61626380.
REQ-033 data_in_valid pulsed during EMIT with different data -> the output stream is unaffected and that block is not consumed.

Source files
------------

// File: rtl/message_schedule_if.sv
// Handshake bundle between message_build, the schedule expander and the round logic.
// The slave side is the schedule block; the master side is the upstream/downstream pair.
interface message_schedule_if;
    logic [511:0] data_in;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;
    logic [31:0]  data_out;
    logic [5:0]   data_out_index;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;

    modport master (
        output data_in, data_in_last, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_index, data_out_last, data_out_valid
    );

    modport slave (
        input  data_in, data_in_last, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_index, data_out_last, data_out_valid
    );
endinterface

// File: rtl/message_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..63] using a
// 16-word sliding window, streaming one word per accepted output transfer.
module message_schedule (
    input  logic               clk,
    input  logic               rst,
    message_schedule_if.slave  bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_next;
    logic [31:0] w [16];
    logic [5:0]  t;
    logic        last_q;
    logic        in_ready;
    logic        out_valid;
    logic        in_fire;
    logic        out_fire;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_fire  = bus.data_in_valid & in_ready;
    assign out_fire = out_valid & bus.data_out_ready;
    assign w_new    = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_fire) state_next = EMIT;
            EMIT:    if (out_fire && t == 6'd63) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            t         <= '0;
            last_q    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == EMIT);
            if (in_fire) begin
                for (int unsigned i = 0; i < 16; i++) w[i] <= bus.data_in[511 - 32*i -: 32];
                last_q <= bus.data_in_last;
                t      <= '0;
            end else if (out_fire) begin
                for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
                w[15] <= w_new;
                t     <= t + 6'd1;
            end
        end
    end

    assign bus.data_in_ready  = in_ready;
    assign bus.data_out_valid = out_valid;
    assign bus.data_out       = w[0];
    assign bus.data_out_index = t;
    assign bus.data_out_last  = out_valid & last_q & (t == 6'd63);
endmodule

// File: tb/tb_message_schedule.sv
// Directed bench for message_schedule: "abc" and zero blocks, stalls,
// back-to-back blocks, mid-block reset and ignored input during EMIT.
module tb_message_schedule;
    logic clk = 1'b0;
    logic rst;
    message_schedule_if bus ();

    message_schedule dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_w  [64];
    logic [31:0] got_w  [64];
    logic [5:0]  got_idx[64];
    logic        got_last[64];
    int          pos;

    logic [511:0] abc_blk;
    logic [511:0] zero_blk;
    logic [511:0] junk_blk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrence over the full W array, independent of the window form.
    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0, s1;
        for (int k = 0; k < 16; k++) exp_w[k] = blk[511 - 32*k -: 32];
        for (int k = 16; k < 64; k++) begin
            s0 = rotr(exp_w[k-15], 7) ^ rotr(exp_w[k-15], 18) ^ (exp_w[k-15] >> 3);
            s1 = rotr(exp_w[k-2], 17) ^ rotr(exp_w[k-2], 19) ^ (exp_w[k-2] >> 10);
            exp_w[k] = s1 + exp_w[k-7] + s0 + exp_w[k-16];
        end
    endtask

    task automatic send(input logic [511:0] blk, input logic last);
        int cyc = 0;
        bus.data_in       = blk;
        bus.data_in_last  = last;
        bus.data_in_valid = 1'b1;
        while (!bus.data_in_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        if (!bus.data_in_ready) check("in_ready_timeout", 64'd0, 64'd1);
        tick();
        bus.data_in_valid = 1'b0;
        check("latency_valid", 64'(bus.data_out_valid), 64'd1);
        check("latency_index", 64'(bus.data_out_index), 64'd0);
    endtask

    task automatic receive(input int n, input bit stall);
        int got = 0;
        int cyc = 0;
        logic [63:0] snap;
        while (got < n && cyc < 2000) begin
            bus.data_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.data_out_valid && bus.data_out_ready) begin
                got_w[pos]    = bus.data_out;
                got_idx[pos]  = bus.data_out_index;
                got_last[pos] = bus.data_out_last;
                pos++;
                got++;
                tick();
            end else if (bus.data_out_valid) begin
                snap = {25'd0, bus.data_out, bus.data_out_index, bus.data_out_last};
                tick();
                check("stall_hold", {25'd0, bus.data_out, bus.data_out_index, bus.data_out_last}, snap);
            end else begin
                tick();
            end
            cyc++;
        end
        bus.data_out_ready = 1'b0;
        if (got < n) check("rx_timeout", 64'(got), 64'(n));
    endtask

    task automatic check_block(input string tag, input logic is_last);
        for (int k = 0; k < 64; k++) begin
            check($sformatf("%s_w%0d", tag, k), 64'(got_w[k]), 64'(exp_w[k]));
            check($sformatf("%s_idx%0d", tag, k), 64'(got_idx[k]), 64'(k));
            check($sformatf("%s_last%0d", tag, k), 64'(got_last[k]), 64'(is_last && k == 63));
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_in_ready"}, 64'(bus.data_in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(bus.data_out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
        zero_blk = '0;
        junk_blk = {16{32'hDEADBEEF}};

        rst                = 1'b1;
        bus.data_in        = '0;
        bus.data_in_last   = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(bus.data_in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.data_out_valid), 64'd0);
        check("rst_data", 64'(bus.data_out), 64'd0);
        check("rst_index", 64'(bus.data_out_index), 64'd0);
        check("rst_last", 64'(bus.data_out_last), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(bus.data_in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.data_out_valid), 64'd0);

        // "abc" block, consumer always ready
        build_model(abc_blk);
        pos = 0;
        send(abc_blk, 1'b1);
        receive(64, 1'b0);
        check_block("abc", 1'b1);
        check("abc_W0", 64'(got_w[0]), 64'h61626380);
        check("abc_W15", 64'(got_w[15]), 64'h00000018);
        check("abc_W16", 64'(got_w[16]), 64'h61626380);
        check("abc_W17", 64'(got_w[17]), 64'h000F0000);
        check("abc_W18", 64'(got_w[18]), 64'h7DA86405);
        check_done("abc_done");

        // all-zero block, not last
        build_model(zero_blk);
        pos = 0;
        send(zero_blk, 1'b0);
        receive(64, 1'b0);
        check_block("zero", 1'b0);
        check_done("zero_done");

        // "abc" with random consumer stalls
        build_model(abc_blk);
        pos = 0;
        send(abc_blk, 1'b1);
        receive(64, 1'b1);
        check_block("stall", 1'b1);
        check_done("stall_done");

        // back-to-back blocks with data_in_valid held high
        build_model(zero_blk);
        pos = 0;
        bus.data_in       = zero_blk;
        bus.data_in_last  = 1'b0;
        bus.data_in_valid = 1'b1;
        check("b2b_ready0", 64'(bus.data_in_ready), 64'd1);
        tick();
        bus.data_in      = abc_blk;
        bus.data_in_last = 1'b1;
        receive(64, 1'b0);
        check_block("b2b0", 1'b0);
        check("b2b_gap_ready", 64'(bus.data_in_ready), 64'd1);
        tick();
        bus.data_in_valid = 1'b0;
        check("b2b_accept_valid", 64'(bus.data_out_valid), 64'd1);
        check("b2b_accept_index", 64'(bus.data_out_index), 64'd0);
        check("b2b_accept_w0", 64'(bus.data_out), 64'h61626380);
        build_model(abc_blk);
        pos = 0;
        receive(64, 1'b0);
        check_block("b2b1", 1'b1);
        check_done("b2b_done");

        // reset at t=20 abandons the block
        pos = 0;
        send(abc_blk, 1'b1);
        receive(20, 1'b0);
        check("mid_index20", 64'(bus.data_out_index), 64'd20);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 64'(bus.data_out_valid), 64'd0);
        check("mid_rst_data", 64'(bus.data_out), 64'd0);
        check("mid_rst_ready", 64'(bus.data_in_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("mid_post_ready", 64'(bus.data_in_ready), 64'd1);
        check("mid_post_valid", 64'(bus.data_out_valid), 64'd0);
        build_model(abc_blk);
        pos = 0;
        send(abc_blk, 1'b1);
        receive(64, 1'b0);
        check_block("restart", 1'b1);
        check_done("restart_done");

        // input offered during EMIT is ignored and not consumed
        build_model(abc_blk);
        pos = 0;
        send(abc_blk, 1'b0);
        receive(10, 1'b0);
        bus.data_in       = junk_blk;
        bus.data_in_last  = 1'b1;
        bus.data_in_valid = 1'b1;
        check("ign_ready_emit", 64'(bus.data_in_ready), 64'd0);
        receive(5, 1'b0);
        bus.data_in_valid = 1'b0;
        receive(49, 1'b0);
        check_block("ign", 1'b0);
        check_done("ign_done");
        tick();
        tick();
        check("ign_not_consumed", 64'(bus.data_out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
